// File: rtl/fb_pkg.sv
// Shared frame-buffer types and constants for the sprite blitter.
package fb_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int FB_AW    = 19;

    typedef logic [7:0] pixel_t;
    localparam pixel_t TRANSPARENT = 8'h00;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
endpackage

// File: rtl/blit_addr_gen.sv
// Row-major pixel walker: column/row counters, ROM pointer, frame row base
// and clip flags, all advanced by increments only.
module blit_addr_gen
    import fb_pkg::*;
#(
    parameter int SCREEN_W = fb_pkg::SCREEN_W,
    parameter int SCREEN_H = fb_pkg::SCREEN_H,
    parameter int ROM_AW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [6:0]        w,
    input  logic [6:0]        h,
    input  logic [ROM_AW-1:0] base,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [FB_AW-1:0]  fb_addr,
    output logic              in_bounds,
    output logic              last
);
    localparam logic [FB_AW-1:0] ROW_STEP = FB_AW'(SCREEN_W);

    logic [6:0]        col_q, col_d, row_q, row_d, w_q, w_d, h_q, h_d;
    logic [ROM_AW-1:0] ptr_q, ptr_d;
    logic [10:0]       x0_q, x0_d, xs_q, xs_d, ys_q, ys_d;
    logic [FB_AW-1:0]  row_base_q, row_base_d, y_base;
    logic              row_end;

    // Constant-coefficient product; only evaluated once per request.
    assign y_base  = FB_AW'(y) * ROW_STEP;
    assign row_end = (col_q == w_q - 7'd1);

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        w_d        = w_q;
        h_d        = h_q;
        ptr_d      = ptr_q;
        x0_d       = x0_q;
        xs_d       = xs_q;
        ys_d       = ys_q;
        row_base_d = row_base_q;
        if (load) begin
            col_d      = '0;
            row_d      = '0;
            w_d        = w;
            h_d        = h;
            ptr_d      = base;
            x0_d       = {1'b0, x};
            xs_d       = {1'b0, x};
            ys_d       = {1'b0, y};
            row_base_d = y_base;
        end else if (step) begin
            ptr_d = ptr_q + 1'b1;
            if (row_end) begin
                col_d      = '0;
                row_d      = row_q + 7'd1;
                xs_d       = x0_q;
                ys_d       = ys_q + 11'd1;
                row_base_d = row_base_q + ROW_STEP;
            end else begin
                col_d = col_q + 7'd1;
                xs_d  = xs_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            w_q        <= '0;
            h_q        <= '0;
            ptr_q      <= '0;
            x0_q       <= '0;
            xs_q       <= '0;
            ys_q       <= '0;
            row_base_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            w_q        <= w_d;
            h_q        <= h_d;
            ptr_q      <= ptr_d;
            x0_q       <= x0_d;
            xs_q       <= xs_d;
            ys_q       <= ys_d;
            row_base_q <= row_base_d;
        end
    end

    // 11-bit screen coordinates so off-screen sprites never wrap back on.
    assign rom_addr  = ptr_q;
    assign fb_addr   = row_base_q + FB_AW'(xs_q);
    assign in_bounds = (xs_q < 11'(SCREEN_W)) && (ys_q < 11'(SCREEN_H));
    assign last      = row_end && (row_q == h_q - 7'd1);
endmodule

// File: rtl/sprite_blitter.sv
// Sprite/fill blitter: request FSM plus one-stage write pipeline aligned to
// the one-cycle ROM read latency.
module sprite_blitter
    import fb_pkg::*;
#(
    parameter int SCREEN_W = fb_pkg::SCREEN_W,
    parameter int SCREEN_H = fb_pkg::SCREEN_H,
    parameter int ROM_AW   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [9:0]        req_x,
    input  logic [9:0]        req_y,
    input  logic [6:0]        req_w,
    input  logic [6:0]        req_h,
    input  logic [ROM_AW-1:0] req_base,
    input  logic              req_fill,
    input  logic [7:0]        req_color,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              WE,
    output logic [FB_AW-1:0]  frame_write_addr,
    output logic [7:0]        frame_data_in,
    output logic              busy,
    output logic              done
);
    state_e           state_q, state_d;
    logic             fill_q, fill_d, done_q, done_d, vld_q, vld_d;
    pixel_t           color_q, color_d;
    logic [FB_AW-1:0] wa_q, wa_d, fb_addr;
    logic             accept, empty, step, in_bounds, last;

    assign accept = (state_q == IDLE) && req_valid;
    assign empty  = (req_w == 7'd0) || (req_h == 7'd0);
    assign step   = (state_q == RUN);

    blit_addr_gen #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .ROM_AW   (ROM_AW)
    ) u_addr_gen (
        .clk       (Clk),
        .reset     (Reset),
        .load      (accept),
        .step      (step),
        .x         (req_x),
        .y         (req_y),
        .w         (req_w),
        .h         (req_h),
        .base      (req_base),
        .rom_addr  (rom_addr),
        .fb_addr   (fb_addr),
        .in_bounds (in_bounds),
        .last      (last)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:  if (accept) begin
                       state_d = empty ? IDLE : RUN;
                       done_d  = empty;
                   end
            RUN:   if (last) state_d = DRAIN;
            DRAIN: begin
                       state_d = IDLE;
                       done_d  = 1'b1;
                   end
            default: state_d = IDLE;
        endcase
        fill_d  = accept ? req_fill  : fill_q;
        color_d = accept ? req_color : color_q;
        vld_d   = step && in_bounds;
        wa_d    = step ? fb_addr : wa_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            fill_q  <= 1'b0;
            color_q <= '0;
            vld_q   <= 1'b0;
            wa_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            fill_q  <= fill_d;
            color_q <= color_d;
            vld_q   <= vld_d;
            wa_q    <= wa_d;
        end
    end

    // ROM data arrives in the same cycle as the staged pixel, so the
    // transparency test is the only combinational term on the write strobe.
    assign WE               = vld_q && (fill_q || rom_data != TRANSPARENT);
    assign frame_data_in    = vld_q ? (fill_q ? color_q : rom_data) : '0;
    assign frame_write_addr = wa_q;
    assign req_ready        = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, frame width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 480, frame height in pixels.
REQ-003 SHALL have parameter ROM_AW, default 16, sprite ROM address width.
REQ-004 SHALL use one clock and a synchronous, active-high reset, as ports Clk and Reset.
REQ-005 Clk  input  1  system clock; all state changes on its rising edge.
REQ-006 Reset  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  draw request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_x, req_y  input  10 each  top-left screen coordinate.
REQ-010 req_w, req_h  input  7 each  sprite width/height, 0..64.
REQ-011 req_base  input  ROM_AW  sprite start address in ROM.
REQ-012 req_fill  input  1  1 = solid fill with req_color, no ROM reads.
REQ-013 req_color  input  8  fill colour.
REQ-014 rom_addr  output  ROM_AW  sprite ROM read address.
REQ-015 rom_data  input  8  ROM data, valid exactly one cycle after rom_addr.
REQ-016 WE  output  1  frame write strobe.
REQ-017 frame_write_addr  output  19  frame write address.
REQ-018 frame_data_in  output  8  frame write pixel.
REQ-019 busy  output  1  a request is in progress.
REQ-020 done  output  1  one-cycle pulse when a request completes.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DRAIN: IDLE->RUN on accept; RUN->DRAIN after the last pixel is issued; DRAIN->IDLE after one cycle.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid && req_ready, and all req_* are latched then.
REQ-023 busy SHALL be 1 in RUN and DRAIN.
REQ-024 In RUN, one pixel SHALL be issued per cycle in row-major order (col 0..w-1 within row, then row+1).
REQ-025 ROM address for pixel (row,col) SHALL be req_base + row*w + col, from a running pointer incremented by 1 per pixel (no multiplier), wrapping modulo 2^ROM_AW.
REQ-026 Frame address SHALL be (y+row)*SCREEN_W + (x+col), from a running row base incremented by SCREEN_W per row (no multiplier).
REQ-027 Accept at cycle 0: pixel i (0-based) SHALL be written at cycle i+2 if enabled; done=1 and req_ready=1 at cycle N+2, with N=w*h.
REQ-028 A pixel write SHALL be suppressed (WE=0) when x+col >= SCREEN_W or y+row >= SCREEN_H; sums SHALL be computed at 11 bits so no wrap-around occurs.
REQ-029 In sprite mode a pixel with rom_data == 8'h00 SHALL be transparent (WE=0).
REQ-030 In fill mode every in-bounds pixel SHALL be written with req_color, including 8'h00; rom_addr is don't-care.
REQ-031 w==0 or h==0 SHALL be accepted, produce no writes, and pulse done at cycle 1.
REQ-032 When WE=0, frame_write_addr and frame_data_in are don't-care.
REQ-033 req_valid or req_* changes while busy SHALL have no effect.

Reset
REQ-034 Reset SHALL force state IDLE, WE=0, done=0, busy=0, req_ready=1, rom_addr=0, frame_write_addr=0, frame_data_in=0 on the next edge.
REQ-035 Reset mid-RUN/DRAIN SHALL abort: no WE after the reset edge and no done pulse for the aborted request.

Structure
REQ-036 Package fb_pkg SHALL hold SCREEN_W, SCREEN_H, FB_AW=19, pixel_t (8-bit), TRANSPARENT=8'h00, and the FSM state enum.
REQ-037 Counters and address generation (col, row, ROM pointer, frame row base, clip flags) SHALL live in a sub-module blit_addr_gen; the top holds the FSM and the one-stage write pipeline.

Verification
REQ-038 Sprite 4x2 at (10,20), base 0x0100, ROM = 1..8: writes at addresses 12810..12813 and 13450..13453 with data 1..8, cycles 2..9; done at cycle 10.
REQ-039 Transparency: same request with ROM entry 0x0103 = 0: exactly 7 writes, no write to 12813.
REQ-040 Clipping: 8x8 fill at (636,476), colour 0x5A: exactly 16 writes (cols 636..639 x rows 476..479); done at cycle 66.
REQ-041 w=0 request: no WE, done at cycle 1, req_ready high at cycle 1; back-to-back valid accepted then.
REQ-042 Reset asserted at cycle 5 of a 64x64 fill: WE=0 from the next cycle, no done, req_ready=1, and the next request runs normally.
